ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_pkg.sv | 19 +
 rtl/rr_arb2.sv | 23 ++
 rtl/ram_arbiter.sv | 138 +++++++++++++
 tb/tb_ram_arbiter.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the RAM arbiter slice.
//   DEFAULT_DATA_WIDTH / DEFAULT_ADDR_WIDTH : default RAM word and address widths
//   state_t                                 : arbiter FSM state encoding
//   LAST_GRANT_RESET                        : last_grant value after reset, so req0
//                                             wins the first tie
package ram_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    localparam logic LAST_GRANT_RESET = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin pick.
//   valid0, valid1 : pending requests
//   last_grant     : requester granted most recently
//   gnt_valid      : at least one requester is pending
//   gnt_id         : winner; on a tie the requester not granted last wins
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_id
);

    always_comb begin
        gnt_valid = valid0 | valid1;
        if (valid0 && valid1) begin
            gnt_id = ~last_grant;
        end else begin
            gnt_id = valid1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with a registered read.
//   clk, reset                : clock, synchronous active-high reset
//   reqN_valid/we/addr/wdata  : request from requester N (held until ready)
//   reqN_ready                : accept strobe, only in IDLE for the winner
//   reqN_rvalid/rdata         : one-cycle read return to the request owner
//   ram_addr/ram_data/ram_we  : shared RAM port, driven from latched request
//   ram_q                     : RAM read data, valid one cycle after address
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  req0_rvalid,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  req1_rvalid,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    state_t                  state;
    state_t                  state_next;
    logic                    last_grant;
    logic                    gnt_valid;
    logic                    gnt_id;
    logic                    accept;

    logic                    req_we_p0;
    logic [ADDR_WIDTH-1:0]   req_addr_p0;
    logic [DATA_WIDTH-1:0]   req_wdata_p0;
    logic                    owner_p0;

    rr_arb2 u_rr_arb2 (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ram_we and ready are qualified with reset so that an access caught in
    // ISSUE by reset never reaches the RAM and nothing is accepted in reset.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        ram_we     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_valid && !reset) begin
                    accept     = 1'b1;
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ram_we     = req_we_p0 & ~reset;
                state_next = req_we_p0 ? ST_IDLE : ST_READ;
            end
            ST_READ: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Stage p0: request latched at the handshake; drives the RAM port in ISSUE
    // and keeps it unchanged afterwards until the next accepted request.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_we_p0    <= 1'b0;
            req_addr_p0  <= '0;
            req_wdata_p0 <= '0;
            owner_p0     <= 1'b0;
            last_grant   <= LAST_GRANT_RESET;
        end else if (accept) begin
            req_we_p0    <= gnt_id ? req1_we    : req0_we;
            req_addr_p0  <= gnt_id ? req1_addr  : req0_addr;
            req_wdata_p0 <= gnt_id ? req1_wdata : req0_wdata;
            owner_p0     <= gnt_id;
            last_grant   <= gnt_id;
        end
    end

    assign ram_addr = req_addr_p0;
    assign ram_data = req_wdata_p0;

    // Stage p1: RAM read data captured in READ for the owner only; the other
    // requester's rdata register is left untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            req0_rdata  <= '0;
            req1_rdata  <= '0;
        end else begin
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            if (state == ST_READ) begin
                if (owner_p0) begin
                    req1_rdata  <= ram_q;
                    req1_rvalid <= 1'b1;
                end else begin
                    req0_rdata  <= ram_q;
                    req0_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    localparam int AW = 10;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0, req0_we = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req1_valid = 1'b0, req1_we = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic          req0_ready, req0_rvalid, req1_ready, req1_rvalid;
    logic [DW-1:0] req0_rdata, req1_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_we;
    logic [DW-1:0] ram_q = '0;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
    );

    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
    typedef struct { int c; logic id; logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } ev_t;

    req_t p0[$], p1[$];
    ev_t  grant_q[$], write_q[$], rv_q[$];
    int   cyc = 0;
    int   checks = 0, errors = 0;
    logic hs0 = 1'b0, hs1 = 1'b0;
    logic ref_last = 1'b1;

    // Registered-read RAM; never-written words read as zero.
    logic [DW-1:0]   mem [0:(1<<AW)-1];
    logic [(1<<AW)-1:0] written = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) begin
            mem[ram_addr]     <= ram_data;
            written[ram_addr] <= 1'b1;
        end
        ram_q <= written[ram_addr] ? mem[ram_addr] : '0;
    end

    always @(negedge clk) begin
        hs0 = req0_valid && req0_ready;
        hs1 = req1_valid && req1_ready;
        if (hs0) grant_q.push_back('{c:cyc, id:1'b0, we:req0_we, addr:req0_addr, data:req0_wdata});
        if (hs1) grant_q.push_back('{c:cyc, id:1'b1, we:req1_we, addr:req1_addr, data:req1_wdata});
        if (ram_we) write_q.push_back('{c:cyc, id:1'b0, we:1'b1, addr:ram_addr, data:ram_data});
        if (req0_rvalid) rv_q.push_back('{c:cyc, id:1'b0, we:1'b0, addr:'0, data:req0_rdata});
        if (req1_rvalid) rv_q.push_back('{c:cyc, id:1'b1, we:1'b0, addr:'0, data:req1_rdata});
    end

    task automatic apply();
        req0_valid = (p0.size() > 0);
        if (p0.size() > 0) begin
            req0_we = p0[0].we; req0_addr = p0[0].addr; req0_wdata = p0[0].data;
        end
        req1_valid = (p1.size() > 0);
        if (p1.size() > 0) begin
            req1_we = p1[0].we; req1_addr = p1[0].addr; req1_wdata = p1[0].data;
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        if (hs0 && p0.size() > 0) void'(p0.pop_front());
        if (hs1 && p1.size() > 0) void'(p1.pop_front());
        apply();
    endtask

    task automatic clear_logs();
        grant_q.delete(); write_q.delete(); rv_q.delete();
    endtask

    task automatic run_until_empty(input int budget, output bit timeout);
        int n = 0;
        while ((p0.size() > 0 || p1.size() > 0) && n < budget) begin
            step();
            n++;
        end
        timeout = (p0.size() > 0 || p1.size() > 0);
        repeat (4) step();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        p0.delete(); p1.delete();
        apply();
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
        ref_last = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = AW'($urandom); req0_wdata = DW'($urandom);
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = AW'($urandom);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({ram_we, req0_ready, req1_ready, req0_rvalid, req1_rvalid} !== 5'b0) begin
                errors++;
                $display("FAIL reset_ctrl: we/rdy0/rdy1/rv0/rv1 got %b expected 00000",
                         {ram_we, req0_ready, req1_ready, req0_rvalid, req1_rvalid});
            end
            checks++;
            if ({ram_addr, ram_data, req0_rdata, req1_rdata} !== '0) begin
                errors++;
                $display("FAIL reset_data: addr=%0h data=%0h rd0=%0h rd1=%0h expected all 0",
                         ram_addr, ram_data, req0_rdata, req1_rdata);
            end
        end
        p0.delete(); p1.delete();
        apply();
        @(posedge clk); #1 reset = 1'b0;
        ref_last = 1'b1;
    endtask

    task automatic test_write_read();
        int t0, t1;
        bit to;
        clear_logs();
        p0.push_back('{we:1'b1, addr:AW'(13), data:DW'(3)});
        apply();
        t0 = cyc;
        run_until_empty(10, to);
        checks++;
        if (to || grant_q.size() != 1 || grant_q[0].id !== 1'b0 || grant_q[0].c != t0) begin
            errors++;
            $display("FAIL wr_handshake: grants=%0d first_cycle=%0d expected 1 grant of req0 at %0d",
                     grant_q.size(), (grant_q.size() > 0) ? grant_q[0].c : -1, t0);
        end
        checks++;
        if (write_q.size() != 1) begin
            errors++;
            $display("FAIL wr_count: got %0d ram_we cycles expected 1", write_q.size());
        end else begin
            checks++;
            if (write_q[0].c != t0 + 1 || write_q[0].addr !== AW'(13) || write_q[0].data !== DW'(3)) begin
                errors++;
                $display("FAIL wr_port: cycle=%0d addr=%0d data=%0d expected cycle=%0d addr=13 data=3",
                         write_q[0].c, write_q[0].addr, write_q[0].data, t0 + 1);
            end
        end
        ref_last = 1'b0;

        clear_logs();
        p1.push_back('{we:1'b0, addr:AW'(13), data:DW'(0)});
        apply();
        t1 = cyc;
        run_until_empty(10, to);
        checks++;
        if (to || grant_q.size() != 1 || grant_q[0].id !== 1'b1 || grant_q[0].c != t1) begin
            errors++;
            $display("FAIL rd_handshake: grants=%0d first_cycle=%0d expected 1 grant of req1 at %0d",
                     grant_q.size(), (grant_q.size() > 0) ? grant_q[0].c : -1, t1);
        end
        checks++;
        if (rv_q.size() != 1) begin
            errors++;
            $display("FAIL rd_count: got %0d rvalid pulses expected 1", rv_q.size());
        end else begin
            checks++;
            if (rv_q[0].id !== 1'b1 || rv_q[0].c != t1 + 3 || rv_q[0].data !== DW'(3)) begin
                errors++;
                $display("FAIL rd_return: id=%0d cycle=%0d data=%0d expected id=1 cycle=%0d data=3",
                         rv_q[0].id, rv_q[0].c, rv_q[0].data, t1 + 3);
            end
        end
        checks++;
        if (write_q.size() != 0 || req0_rdata !== '0) begin
            errors++;
            $display("FAIL rd_side_effects: writes=%0d rdata0=%0h expected 0 and 0",
                     write_q.size(), req0_rdata);
        end
        ref_last = 1'b1;
    endtask

    task automatic test_tie();
        int t0;
        bit to;
        do_reset(2);
        clear_logs();
        p0.push_back('{we:1'b1, addr:AW'(42), data:DW'(43)});
        p1.push_back('{we:1'b1, addr:AW'(1023), data:DW'(1776)});
        apply();
        t0 = cyc;
        run_until_empty(20, to);
        checks++;
        if (to || grant_q.size() != 2) begin
            errors++;
            $display("FAIL tie_grants: got %0d grants expected 2", grant_q.size());
        end else begin
            checks++;
            if (grant_q[0].id !== 1'b0 || grant_q[1].id !== 1'b1 || grant_q[1].c != t0 + 2) begin
                errors++;
                $display("FAIL tie_order: ids=%0d,%0d second_cycle=%0d expected 0,1 at %0d",
                         grant_q[0].id, grant_q[1].id, grant_q[1].c, t0 + 2);
            end
        end
        checks++;
        if (write_q.size() != 2) begin
            errors++;
            $display("FAIL tie_writes: got %0d writes expected 2", write_q.size());
        end else begin
            checks++;
            if (write_q[0].addr !== AW'(42) || write_q[0].data !== DW'(43) ||
                write_q[1].addr !== AW'(1023) || write_q[1].data !== DW'(1776)) begin
                errors++;
                $display("FAIL tie_write_data: got %0d/%0d then %0d/%0d expected 42/43 then 1023/1776",
                         write_q[0].addr, write_q[0].data, write_q[1].addr, write_q[1].data);
            end
        end
        ref_last = 1'b1;

        clear_logs();
        p0.push_back('{we:1'b1, addr:AW'(5), data:DW'(6)});
        p1.push_back('{we:1'b1, addr:AW'(7), data:DW'(8)});
        apply();
        run_until_empty(20, to);
        checks++;
        if (to || grant_q.size() == 0 || grant_q[0].id !== !ref_last) begin
            errors++;
            $display("FAIL tie_repeat: first id=%0d expected %0d",
                     (grant_q.size() > 0) ? int'(grant_q[0].id) : -1, int'(!ref_last));
        end
        ref_last = 1'b1;
    endtask

    task automatic test_alternation();
        bit to;
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            p0.push_back('{we:1'($urandom), addr:AW'(200 + $urandom_range(0, 15)), data:DW'($urandom)});
            p1.push_back('{we:1'($urandom), addr:AW'(200 + $urandom_range(0, 15)), data:DW'($urandom)});
        end
        apply();
        run_until_empty(100, to);
        checks++;
        if (to || grant_q.size() != 8) begin
            errors++;
            $display("FAIL alt_count: got %0d grants expected 8", grant_q.size());
        end
        for (int k = 0; k < grant_q.size() && k < 8; k++) begin
            logic exp_id;
            exp_id = (k % 2 == 0) ? !ref_last : ref_last;
            checks++;
            if (grant_q[k].id !== exp_id) begin
                errors++;
                $display("FAIL alt_order[%0d]: got id %0d expected %0d", k, grant_q[k].id, exp_id);
            end
        end
        ref_last = 1'b1;
    endtask

    task automatic test_boundary();
        bit to;
        clear_logs();
        p1.push_back('{we:1'b1, addr:AW'(1023), data:16'hFFFF});
        p1.push_back('{we:1'b1, addr:AW'(0), data:16'h1234});
        apply();
        run_until_empty(20, to);
        p0.push_back('{we:1'b0, addr:AW'(1023), data:DW'(0)});
        p0.push_back('{we:1'b0, addr:AW'(0), data:DW'(0)});
        apply();
        run_until_empty(20, to);
        checks++;
        if (write_q.size() != 2 || write_q[0].addr !== AW'(1023) || write_q[1].addr !== AW'(0)) begin
            errors++;
            $display("FAIL edge_write_addr: count=%0d first=%0d expected 2 writes to 1023 then 0",
                     write_q.size(), (write_q.size() > 0) ? int'(write_q[0].addr) : -1);
        end
        checks++;
        if (to || rv_q.size() != 2) begin
            errors++;
            $display("FAIL edge_read_count: got %0d rvalid pulses expected 2", rv_q.size());
        end else begin
            checks++;
            if (rv_q[0].id !== 1'b0 || rv_q[0].data !== 16'hFFFF) begin
                errors++;
                $display("FAIL edge_read_1023: id=%0d data=%0h expected id=0 data=ffff",
                         rv_q[0].id, rv_q[0].data);
            end
            checks++;
            if (rv_q[1].id !== 1'b0 || rv_q[1].data !== 16'h1234) begin
                errors++;
                $display("FAIL edge_read_0: id=%0d data=%0h expected id=0 data=1234",
                         rv_q[1].id, rv_q[1].data);
            end
        end
        ref_last = 1'b0;
    endtask

    task automatic test_reset_during_issue();
        bit to;
        bit seen;
        clear_logs();
        p0.push_back('{we:1'b1, addr:AW'(66), data:16'h0A0A});
        apply();
        run_until_empty(20, to);
        clear_logs();
        p0.push_back('{we:1'b1, addr:AW'(66), data:16'h5555});
        apply();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk); #1;
            seen = hs0;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL abort_handshake: got no ready0 within 10 cycles expected one");
        end
        step();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b0) begin
            errors++;
            $display("FAIL abort_we: got ram_we=%b during reset expected 0", ram_we);
        end
        @(posedge clk); #1 reset = 1'b0;
        ref_last = 1'b1;
        repeat (5) step();
        checks++;
        if (write_q.size() != 0 || rv_q.size() != 0) begin
            errors++;
            $display("FAIL abort_dropped: got %0d writes %0d rvalids expected 0 and 0",
                     write_q.size(), rv_q.size());
        end
        clear_logs();
        p1.push_back('{we:1'b0, addr:AW'(66), data:DW'(0)});
        apply();
        run_until_empty(20, to);
        checks++;
        if (rv_q.size() != 1 || rv_q[0].id !== 1'b1 || rv_q[0].data !== 16'h0A0A) begin
            errors++;
            $display("FAIL abort_readback: count=%0d data=%0h expected 1 return of 0a0a to req1",
                     rv_q.size(), (rv_q.size() > 0) ? rv_q[0].data : 16'h0);
        end
        ref_last = 1'b1;
    endtask

    // Transaction-level model: grant order from the round-robin rule, grant
    // spacing of 2 (write) or 3 (read) cycles, writes at +1, returns at +3
    // carrying the most recent value written to that address.
    task automatic test_random();
        logic [DW-1:0] rm [16];
        for (int a = 0; a < 16; a++) rm[a] = '0;
        for (int r = 0; r < 3; r++) begin
            req_t e0[$], e1[$];
            ev_t  eg[$], ew[$], er[$];
            int   n0, n1, i0, i1, t0, expc;
            logic last;
            bit   to;
            n0 = (r == 2) ? 0 : $urandom_range(5, 12);
            n1 = (r == 1) ? 0 : $urandom_range(5, 12);
            for (int i = 0; i < n0; i++)
                e0.push_back('{we:1'($urandom), addr:AW'(100 + $urandom_range(0, 15)), data:DW'($urandom)});
            for (int i = 0; i < n1; i++)
                e1.push_back('{we:1'($urandom), addr:AW'(100 + $urandom_range(0, 15)), data:DW'($urandom)});
            clear_logs();
            foreach (e0[i]) p0.push_back(e0[i]);
            foreach (e1[i]) p1.push_back(e1[i]);
            apply();
            t0 = cyc;
            expc = t0;
            i0 = 0; i1 = 0; last = ref_last;
            while (i0 < n0 || i1 < n1) begin
                logic pick;
                req_t q;
                if (i0 < n0 && i1 < n1) pick = !last;
                else pick = (i1 < n1);
                if (pick) begin q = e1[i1]; i1++; end
                else begin q = e0[i0]; i0++; end
                last = pick;
                eg.push_back('{c:expc, id:pick, we:q.we, addr:q.addr, data:q.data});
                if (q.we) begin
                    ew.push_back('{c:expc + 1, id:pick, we:1'b1, addr:q.addr, data:q.data});
                    rm[int'(q.addr) - 100] = q.data;
                    expc += 2;
                end else begin
                    er.push_back('{c:expc + 3, id:pick, we:1'b0, addr:'0, data:rm[int'(q.addr) - 100]});
                    expc += 3;
                end
            end
            ref_last = last;
            run_until_empty(400, to);
            checks++;
            if (to || grant_q.size() != eg.size() || write_q.size() != ew.size() || rv_q.size() != er.size()) begin
                errors++;
                $display("FAIL rand_counts[%0d]: grants/writes/reads %0d/%0d/%0d expected %0d/%0d/%0d",
                         r, grant_q.size(), write_q.size(), rv_q.size(), eg.size(), ew.size(), er.size());
            end
            for (int k = 0; k < eg.size() && k < grant_q.size(); k++) begin
                checks++;
                if (grant_q[k].c != eg[k].c || grant_q[k].id !== eg[k].id || grant_q[k].we !== eg[k].we ||
                    grant_q[k].addr !== eg[k].addr) begin
                    errors++;
                    $display("FAIL rand_grant[%0d.%0d]: cyc=%0d id=%0d addr=%0d expected cyc=%0d id=%0d addr=%0d",
                             r, k, grant_q[k].c, grant_q[k].id, grant_q[k].addr, eg[k].c, eg[k].id, eg[k].addr);
                end
            end
            for (int k = 0; k < ew.size() && k < write_q.size(); k++) begin
                checks++;
                if (write_q[k].c != ew[k].c || write_q[k].addr !== ew[k].addr || write_q[k].data !== ew[k].data) begin
                    errors++;
                    $display("FAIL rand_write[%0d.%0d]: cyc=%0d addr=%0d data=%0h expected cyc=%0d addr=%0d data=%0h",
                             r, k, write_q[k].c, write_q[k].addr, write_q[k].data, ew[k].c, ew[k].addr, ew[k].data);
                end
            end
            for (int k = 0; k < er.size() && k < rv_q.size(); k++) begin
                checks++;
                if (rv_q[k].c != er[k].c || rv_q[k].id !== er[k].id || rv_q[k].data !== er[k].data) begin
                    errors++;
                    $display("FAIL rand_read[%0d.%0d]: cyc=%0d id=%0d data=%0h expected cyc=%0d id=%0d data=%0h",
                             r, k, rv_q[k].c, rv_q[k].id, rv_q[k].data, er[k].c, er[k].id, er[k].data);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_tie();
        test_alternation();
        test_boundary();
        test_reset_during_issue();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
